eth_rx_length_dispatch: RTL

Logic-clock-domain controller that sits between the 1G MAC RX data FIFO output and the user RX port, sequenced by the per-frame packet-length FIFO.
- For each frame it pops one length entry and applies a programmable length window:
  - a frame inside the window has its length presented on a descriptor channel, then the frame is forwarded;
  - a frame outside the window is drained and discarded.
- It checks the actual byte count against the popped length and flags mismatches.

---
 rtl/eth_rx_dispatch_pkg.sv | 16 +
 rtl/eth_stat_counter.sv | 19 +
 rtl/eth_rx_length_dispatch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eth_rx_dispatch_pkg.sv
// Shared types and constants for the Ethernet RX length-dispatch controller.
// Optional statistics are enabled by defining ETH_RX_DISPATCH_STATS_EN.
package eth_rx_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DESC = 2'd1,
        FWD  = 2'd2,
        DROP = 2'd3
    } state_t;

    // Recommended cfg_min_len / cfg_max_len values (tagged frame limits).
    localparam int ETH_MIN_FRAME_LEN = 64;
    localparam int ETH_MAX_FRAME_LEN = 1522;

endpackage

// File: rtl/eth_stat_counter.sv
// Saturating event counter with synchronous active-high clear.
module eth_stat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/eth_rx_length_dispatch.sv
// Pops one length entry per RX frame, emits a descriptor and forwards the frame when the
// length is inside the window, otherwise drains it. Stats ports under ETH_RX_DISPATCH_STATS_EN.
module eth_rx_length_dispatch
    import eth_rx_dispatch_pkg::*;
#(
    parameter int LENGTH_WIDTH = 11,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LENGTH_WIDTH-1:0] s_len_tdata,
    input  logic                    s_len_tvalid,
    output logic                    s_len_tready,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [LENGTH_WIDTH-1:0] m_len_tdata,
    output logic                    m_len_tvalid,
    input  logic                    m_len_tready,
    input  logic                    cfg_enable,
    input  logic [LENGTH_WIDTH-1:0] cfg_min_len,
    input  logic [LENGTH_WIDTH-1:0] cfg_max_len,
    output logic                    status_drop,
    output logic                    status_len_error,
    output state_t                  fsm_state
`ifdef ETH_RX_DISPATCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   stat_fwd_frames,
    output logic [STAT_WIDTH-1:0]   stat_drop_frames,
    output logic [STAT_WIDTH-1:0]   stat_len_errors
`endif
);

    if (STAT_WIDTH < 1 || LENGTH_WIDTH < 2) begin : g_param_check
        $error("eth_rx_length_dispatch: unsupported parameter values");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [LENGTH_WIDTH-1:0] len_reg;
    logic [LENGTH_WIDTH-1:0] beat_cnt;
    logic [LENGTH_WIDTH:0]   beat_total;
    logic                    len_pop;
    logic                    in_window;
    logic                    fwd_xfer;
    logic                    drop_xfer;
    logic                    mismatch;

    assign fsm_state = state_q;
    assign len_pop   = s_len_tvalid && s_len_tready;
    assign in_window = (s_len_tdata >= cfg_min_len) && (s_len_tdata <= cfg_max_len);
    assign fwd_xfer  = (state_q == FWD) && s_axis_tvalid && m_axis_tready;
    assign drop_xfer = (state_q == DROP) && s_axis_tvalid;

    // One bit wider so a saturated beat count can never alias a valid length.
    assign beat_total = {1'b0, beat_cnt} + {{LENGTH_WIDTH{1'b0}}, 1'b1};
    assign mismatch   = (beat_total != {1'b0, len_reg});

    always_comb begin
        state_d          = state_q;
        s_len_tready     = 1'b0;
        s_axis_tready    = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tvalid    = 1'b0;
        m_axis_tlast     = 1'b0;
        m_axis_tuser     = 1'b0;
        m_len_tdata      = '0;
        m_len_tvalid     = 1'b0;
        status_drop      = 1'b0;
        status_len_error = 1'b0;
        case (state_q)
            IDLE: begin
                s_len_tready = cfg_enable && !rst;
                if (len_pop) begin
                    if (in_window) begin
                        state_d = DESC;
                    end else begin
                        state_d     = DROP;
                        status_drop = 1'b1;
                    end
                end
            end
            DESC: begin
                m_len_tvalid = 1'b1;
                m_len_tdata  = len_reg;
                if (m_len_tready) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser | (s_axis_tlast & mismatch);
                if (fwd_xfer && s_axis_tlast) begin
                    status_len_error = mismatch;
                    state_d          = IDLE;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (drop_xfer && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg  <= '0;
            beat_cnt <= '0;
        end else if (len_pop) begin
            len_reg  <= s_len_tdata;
            beat_cnt <= '0;
        end else if (fwd_xfer && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef ETH_RX_DISPATCH_STATS_EN
    logic fwd_done;
    assign fwd_done = fwd_xfer && s_axis_tlast;

    eth_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_fwd (
        .clk   (clk),
        .rst   (rst),
        .inc   (fwd_done),
        .count (stat_fwd_frames)
    );

    eth_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (status_drop),
        .count (stat_drop_frames)
    );

    eth_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_len_err (
        .clk   (clk),
        .rst   (rst),
        .inc   (status_len_error),
        .count (stat_len_errors)
    );
`endif

endmodule
